// File: rtl/compare_sequencer_32.sv
// Multi-cycle SLT/SLTU engine: A-B one slice per clock, LSB slice first.
// Valid/ready on both operand intake and result delivery.
module compare_sequencer_32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             unsigned_ctl,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] diff,
  output logic             carryout,
  output logic             zero
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             uns_q;
  logic             carry_q;
  logic [SW-1:0]    step_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] z_q;
  logic             cout_q;
  logic             zero_q;
  logic             valid_q;

  logic [OW-1:0]    off;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sum;
  logic [WIDTH-1:0] diff_d;
  logic             last;
  logic             less;

  // The single narrow subtract slice shared by every RUN step.
  always_comb begin
    off    = OW'(32'(step_q) * SLICE);
    a_sl   = a_q[off +: SLICE];
    b_sl   = b_q[off +: SLICE];
    sum    = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, carry_q};
    diff_d = diff_q;
    diff_d[off +: SLICE] = sum[SLICE-1:0];
    last   = (step_q == SW'(STEPS - 1));
    if (uns_q) begin
      less = ~sum[SLICE];
    end else if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
      less = a_q[WIDTH-1];
    end else begin
      less = diff_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      uns_q   <= 1'b0;
      carry_q <= 1'b1;
      step_q  <= '0;
      diff_q  <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            a_q     <= a;
            b_q     <= b;
            uns_q   <= unsigned_ctl;
            carry_q <= 1'b1;
            step_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else begin
            diff_q  <= diff_d;
            carry_q <= sum[SLICE];
            step_q  <= step_q + 1'b1;
            if (last) begin
              cout_q  <= sum[SLICE];
              zero_q  <= (diff_d == '0);
              z_q     <= WIDTH'(less);
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || res_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign res_valid = valid_q;
  assign z         = z_q;
  assign diff      = diff_q;
  assign carryout  = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_compare_sequencer_32.sv
// Directed bench for compare_sequencer_32.
// Expected values are hand-computed per vector.
module tb_compare_sequencer_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        unsigned_ctl;
  logic        abort;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] z;
  logic [31:0] diff;
  logic        carryout;
  logic        zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  compare_sequencer_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .unsigned_ctl(unsigned_ctl),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .z           (z),
    .diff        (diff),
    .carryout    (carryout),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Accept an op, scramble inputs, wait (bounded) for res_valid.
  task automatic run_op(input string tag, input logic [31:0] av,
                        input logic [31:0] bv, input logic ctl);
    int n;
    start = 1'b1;
    a = av;
    b = bv;
    unsigned_ctl = ctl;
    tick();
    start = 1'b0;
    a = ~av;
    b = bv ^ 32'h5A5A_A5A5;
    unsigned_ctl = ~ctl;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (res_valid) begin
        n = i;
        break;
      end
    end
    check({tag, "_lat"}, 32'(n), 32'd4);
  endtask

  task automatic expect_res(input string tag, input logic [31:0] ez,
                            input logic [31:0] ed, input logic ec,
                            input logic ezr);
    check({tag, "_z"}, z, ez);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_cout"}, 32'(carryout), 32'(ec));
    check({tag, "_zero"}, 32'(zero), 32'(ezr));
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    unsigned_ctl = 1'b0;
    abort = 1'b0;
    res_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_z", z, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_cz", {30'd0, carryout, zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("slt_5_7", 32'd5, 32'd7, 1'b0);
    expect_res("slt_5_7", 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drain();
    check("idle_after_drain", 32'(in_ready), 32'd1);
    check("valid_after_drain", 32'(res_valid), 32'd0);

    run_op("sltu_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b1);
    expect_res("sltu_m1_1", 32'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    drain();
    run_op("slt_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    expect_res("slt_m1_1", 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    drain();

    run_op("slt_ovf1", 32'h8000_0000, 32'd1, 1'b0);
    expect_res("slt_ovf1", 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    drain();
    run_op("slt_ovf2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    expect_res("slt_ovf2", 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    drain();

    run_op("eq_s", 32'h1234_5678, 32'h1234_5678, 1'b0);
    expect_res("eq_s", 32'd0, 32'd0, 1'b1, 1'b1);
    drain();
    run_op("eq_u", 32'h1234_5678, 32'h1234_5678, 1'b1);
    expect_res("eq_u", 32'd0, 32'd0, 1'b1, 1'b1);
    drain();

    run_op("sltu_1_2", 32'd1, 32'd2, 1'b1);
    expect_res("sltu_1_2", 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();

    // Backpressure: result held, starts ignored.
    run_op("bp", 32'd3, 32'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      a = $urandom;
      b = $urandom;
      tick();
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_diff", diff, 32'hFFFF_FFFA);
      check("bp_z", z, 32'd1);
    end
    start = 1'b1;
    a = 32'd100;
    b = 32'd1;
    unsigned_ctl = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check("bp_rel_valid", 32'(res_valid), 32'd0);
    check("bp_hold_diff", diff, 32'hFFFF_FFFA);
    start = 1'b0;
    run_op("bp_next", 32'd100, 32'd1, 1'b0);
    expect_res("bp_next", 32'd0, 32'd99, 1'b1, 1'b0);
    drain();

    // Abort at step 2.
    start = 1'b1;
    a = 32'd5;
    b = 32'd7;
    unsigned_ctl = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("abort_valid_late", 32'(res_valid), 32'd0);

    // Abort in IDLE blocks a simultaneous start.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_idle", 32'(in_ready), 32'd1);

    // Reset mid-RUN is immediate.
    start = 1'b1;
    a = 32'd1;
    b = 32'd2;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_z", z, 32'd0);
    check("mid_rst_diff", diff, 32'd0);
    check("mid_rst_flags", {29'd0, res_valid, carryout, zero}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    run_op("post_rst", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    expect_res("post_rst", 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/compare_sequencer_32.md
Name: compare_sequencer_32

Overview:
- Multi-cycle SLT/SLTU engine for the ALU32 datapath.
- Computes A−B one SLICE-bit chunk per clock through a single narrow subtract slice (A + ~B + carry), LSB chunk first.
- Produces the same 32-bit set-less-than result as the ALU's combinational comparison path: the 0/1 flag in bit 0, zeros above.
- Used where area matters more than latency; operand intake and result delivery use valid/ready handshakes.

Parameters:
- WIDTH, 32, operand width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle.
- STEPS, WIDTH/SLICE (derived localparam, 4 by default), number of RUN cycles.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request valid; operands are presented with it.
- in_ready  out  1  high only in IDLE; a request is accepted on an edge where start & in_ready.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- unsigned_ctl  in  1  0 = SLT (signed), 1 = SLTU (unsigned); sampled on the accepting edge.
- abort  in  1  synchronous cancel of the operation in flight.
- res_valid  out  1  result valid; held until accepted.
- res_ready  in  1  consumer accepts the result on an edge where res_valid & res_ready.
- z  out  WIDTH  {WIDTH-1 zeros, less flag}.
- diff  out  WIDTH  full A−B result.
- carryout  out  1  final carry of A + ~B + 1.
- zero  out  1  diff == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; res_valid=0; z=0; diff=0; carryout=0; zero=0; step counter=0; internal carry=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On start: latch a, b, unsigned_ctl; carry←1; step←0; go to RUN.
  - Without start: stay in IDLE.
- RUN, each edge (step = 0..STEPS-1):
  - diff[step*SLICE +: SLICE] ← A_slice + ~B_slice + carry (SLICE-bit result).
  - carry ← carry-out of that slice addition; step←step+1.
  - On the edge that processes step=STEPS-1: also register carryout, zero, z; go to DONE.
- Final flag computation:
  - SLT: less = (A[W-1] ^ B[W-1]) ? A[W-1] : diff[W-1]. This uses the sign of the completed diff, including the MSB slice written on the same edge.
  - SLTU: less = ~final_carry.
  - z = less zero-extended to WIDTH.
- Latency: res_valid rises exactly STEPS edges after the accepting edge (4 by default). Throughput is one result per STEPS+2 cycles at best.
- DONE:
  - res_valid=1; z, diff, carryout and zero are stable.
  - On res_ready: go to IDLE; res_valid drops; outputs keep their values.
  - in_ready returns only in IDLE, so a start during DONE, or on the same edge as res_ready, is ignored and never queued.
- abort:
  - In RUN or DONE: next state IDLE, res_valid=0.
  - z, diff, carryout and zero are left as-is; diff may be partially updated and must not be relied on.
  - abort has priority over res_ready, and over start on the same edge.
  - In IDLE, abort suppresses acceptance of a simultaneous start.
- Operand isolation: changes on a, b or unsigned_ctl after the accepting edge have no effect on the operation in flight.
- Reset mid-operation: asynchronous return to the reset values above, regardless of state.
- Outputs are registered only; no combinational path from start or res_ready to any output except in_ready, which is decoded from state.

Test Plan:
- Signed a=5, b=7, ctl=0 → after 4 edges: res_valid=1, z=0x00000001, diff=0xFFFFFFFE, carryout=0, zero=0.
- Unsigned a=0xFFFFFFFF, b=1, ctl=1 → z=0, diff=0xFFFFFFFE, carryout=1. Then signed with same operands → z=1.
- Signed overflow a=0x80000000, b=1 → diff=0x7FFFFFFF, z=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF → z=0.
- Equal a=b=0x12345678, both ctl values → zero=1, carryout=1, z=0.
- Backpressure: hold res_ready=0 for 3 cycles and toggle start, a and b → outputs stable, no new accept. Raise res_ready → IDLE, then the next start is accepted.
- abort at step 2 → IDLE next edge, res_valid stays 0. Separately, drop rst_n mid-RUN → all outputs 0 and in_ready=1 immediately.
